// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
//   op_t     : user-visible operation codes (NOR, XOR, ADD, SUB)
//   state_t  : sequencer FSM state encoding
//   SLICE_*  : opcodes understood by the alu1bit slice
//   slice_op : maps a user operation onto the slice opcode
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SLICE_NOR = 2'b00;
    localparam logic [1:0] SLICE_XOR = 2'b01;
    localparam logic [1:0] SLICE_FAS = 2'b10;

    // ADD and SUB share the full-adder slice; SUB differs only in the
    // inverted b input and the carry seed, handled by the sequencer.
    function automatic logic [1:0] slice_op(input logic [1:0] opr);
        logic [1:0] so;
        case (opr)
            OP_NOR:  so = SLICE_NOR;
            OP_XOR:  so = SLICE_XOR;
            default: so = SLICE_FAS;
        endcase
        return so;
    endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice shared by the serial sequencer.
// Ports:
//   a, b  : operand bits
//   cin   : carry in (used by the full-adder op only)
//   op    : 00 NOR, 01 XOR, 10 full add, 11 AND (not used by the sequencer)
//   s     : result bit
//   cout  : carry out (0 for the logic ops)
import alu_ctrl_pkg::*;

module alu1bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);

    always_comb begin
        s    = 1'b0;
        cout = 1'b0;
        case (op)
            SLICE_NOR: s = ~(a | b);
            SLICE_XOR: s = a ^ b;
            SLICE_FAS: begin
                s    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default:   s = a & b;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial NOR/XOR/ADD/SUB sequencer driving a single alu1bit slice,
// one bit per clock, LSB first.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, op,
//   a, b          : request and operands, sampled together in IDLE
//   busy          : high while bits are being processed
//   done          : one-cycle completion pulse
//   result        : registered result (partial while busy)
//   carry         : final carry-out (ADD/SUB; 1 = no borrow for SUB)
//   zero          : result == 0, valid from the done cycle onward
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | waiting for start; outputs hold last operation's values
// RUN   | one bit through the slice per cycle, counter 0..WIDTH-1
// DONE  | done pulse, zero flag valid; always returns to IDLE
import alu_ctrl_pkg::*;

module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [1:0]       opr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic [1:0]       slice_opc;
    logic             slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] result_next;
    logic             is_arith;

    assign is_arith = (opr_q == OP_ADD) || (opr_q == OP_SUB);

    always_comb begin
        slice_a   = sa_q[0];
        slice_b   = (opr_q == OP_SUB) ? ~sb_q[0] : sb_q[0];
        slice_cin = carry_q;
        slice_opc = slice_op(opr_q);
    end

    alu1bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .op   (slice_opc),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    assign result_next = {slice_s, result_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            opr_q    <= 2'b00;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        opr_q   <= op;
                        carry_q <= (op == OP_SUB);
                        zero_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= result_next;
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    carry_q  <= is_arith ? slice_cout : 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        zero_q  <= (result_next == '0);
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule
